// File: rtl/bip_run_ctrl.sv
// -----------------------------------------------------------------------------
// bip_run_ctrl
//
// Run controller for the BIP CPU. It takes commands and program words from a
// UART receive byte stream, writes the words into instruction memory, and
// resets the CPU. It then runs or single-steps the CPU through a clock enable
// and stops it in front of a HALT instruction (opcode 0). When the CPU halts or
// a step ends, it reports PC, ACC and the executed-cycle count to the UART
// transmitter as six little-endian bytes.
//
// Commands received in IDLE:
//   'L' (0x4C) + count lo/hi + count x (word lo, word hi) : load program
//   'R' (0x52)                                              : reset CPU and run
//   'S' (0x53)                                              : single step
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-low reset
//   i_rx_data, i_rx_valid   received byte and its one-cycle valid pulse
//   o_tx_data, o_tx_start   byte to send and its one-cycle start pulse
//   i_tx_busy               transmitter busy
//   o_ins_wr_*              instruction memory write port
//   o_cpu_en, o_cpu_rst     CPU clock enable / active-low CPU reset
//   i_cpu_pc/instruction/acc  CPU status observed for halt and reporting
//   o_state                 current FSM state (debug)
// -----------------------------------------------------------------------------
module bip_run_ctrl #(
  parameter int NB_BITS       = 16,
  parameter int INS_MEM_DEPTH = 2048,
  parameter int NB_OPCODE     = 5,
  parameter int NB_CYCLES     = 16,
  localparam int NB_ADDR      = $clog2(INS_MEM_DEPTH - 1)
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_start,
  input  logic               i_tx_busy,
  output logic [NB_ADDR-1:0] o_ins_wr_addr,
  output logic [NB_BITS-1:0] o_ins_wr_data,
  output logic               o_ins_wr_en,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  input  logic [NB_ADDR-1:0] i_cpu_pc,
  input  logic [NB_BITS-1:0] i_cpu_instruction,
  input  logic [NB_BITS-1:0] i_cpu_acc,
  output logic [3:0]         o_state
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    LD_CNT_L = 4'd1,
    LD_CNT_H = 4'd2,
    LD_WL    = 4'd3,
    LD_WH    = 4'd4,
    CPU_RST  = 4'd5,
    RUN      = 4'd6,
    STEP     = 4'd7,
    REP_SEND = 4'd8,
    REP_WAIT = 4'd9
  } state_t;

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  localparam logic [NB_ADDR-1:0] ADDR_LAST = NB_ADDR'(INS_MEM_DEPTH - 1);

  // Saturating increment of the executed-cycle counter.
  function automatic logic [NB_CYCLES-1:0] sat_inc(input logic [NB_CYCLES-1:0] v);
    if (v == {NB_CYCLES{1'b1}}) return v;
    else                        return v + 1'b1;
  endfunction

  // Address increment that wraps at the memory depth (also for non-power-of-2).
  function automatic logic [NB_ADDR-1:0] addr_inc(input logic [NB_ADDR-1:0] a);
    if (a == ADDR_LAST) return '0;
    else                return a + 1'b1;
  endfunction

  state_t               state;
  logic [15:0]          word_cnt;
  logic [NB_ADDR-1:0]   addr;
  logic [2:0]           idx;
  logic [NB_CYCLES-1:0] cycles;
  logic [NB_CYCLES-1:0] cycles_next;

  // Data-only holding registers (no reset needed).
  logic [7:0]           cnt_lo;
  logic [7:0]           word_lo;
  logic [15:0]          snap_pc;
  logic [15:0]          snap_acc;
  logic [15:0]          snap_cyc;
  logic [7:0]           rep_byte;

  logic halt;
  logic snap_take;

  assign halt     = (i_cpu_instruction[NB_BITS-1 -: NB_OPCODE] == '0);
  assign o_cpu_en = ((state == RUN) || (state == STEP)) && !halt;
  assign o_state  = state;

  // The counter value after this cycle's possible increment; the snapshot uses
  // it so that a step's own cycle is included in its report.
  assign cycles_next = o_cpu_en ? sat_inc(cycles) : cycles;

  // Snapshot on the edge that enters REP_SEND. CPU inputs are sampled as they
  // stand on that edge, i.e. before the CPU applies its last enabled cycle.
  assign snap_take = ((state == RUN) && halt) || (state == STEP);

  always_comb begin
    rep_byte = snap_pc[7:0];
    case (idx)
      3'd0:    rep_byte = snap_pc[7:0];
      3'd1:    rep_byte = snap_pc[15:8];
      3'd2:    rep_byte = snap_acc[7:0];
      3'd3:    rep_byte = snap_acc[15:8];
      3'd4:    rep_byte = snap_cyc[7:0];
      default: rep_byte = snap_cyc[15:8];
    endcase
  end

  // Byte and snapshot capture
  always_ff @(posedge i_clk) begin
    if ((state == LD_CNT_L) && i_rx_valid) cnt_lo  <= i_rx_data;
    if ((state == LD_WL) && i_rx_valid)    word_lo <= i_rx_data;
    if (snap_take) begin
      snap_pc  <= 16'(i_cpu_pc);
      snap_acc <= 16'(i_cpu_acc);
      snap_cyc <= 16'(cycles_next);
    end
  end

  // Control FSM with registered outputs
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state         <= IDLE;
      word_cnt      <= '0;
      addr          <= '0;
      idx           <= '0;
      cycles        <= '0;
      o_tx_data     <= '0;
      o_tx_start    <= 1'b0;
      o_ins_wr_addr <= '0;
      o_ins_wr_data <= '0;
      o_ins_wr_en   <= 1'b0;
      o_cpu_rst     <= 1'b0;
    end else begin
      o_tx_start  <= 1'b0;
      o_ins_wr_en <= 1'b0;
      o_cpu_rst   <= 1'b1;

      if (state == CPU_RST)  cycles <= '0;
      else if (o_cpu_en)     cycles <= sat_inc(cycles);

      case (state)
        IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_data)
              CMD_LOAD: state <= LD_CNT_L;
              CMD_RUN: begin
                state     <= CPU_RST;
                o_cpu_rst <= 1'b0;
              end
              CMD_STEP: state <= STEP;
              default:  state <= IDLE;
            endcase
          end
        end

        LD_CNT_L: if (i_rx_valid) state <= LD_CNT_H;

        LD_CNT_H: begin
          if (i_rx_valid) begin
            word_cnt <= {i_rx_data, cnt_lo};
            addr     <= '0;
            if ({i_rx_data, cnt_lo} == 16'd0) state <= IDLE;
            else                              state <= LD_WL;
          end
        end

        LD_WL: if (i_rx_valid) state <= LD_WH;

        LD_WH: begin
          if (i_rx_valid) begin
            o_ins_wr_en   <= 1'b1;
            o_ins_wr_addr <= addr;
            o_ins_wr_data <= NB_BITS'({i_rx_data, word_lo});
            addr          <= addr_inc(addr);
            word_cnt      <= word_cnt - 16'd1;
            if (word_cnt == 16'd1) state <= IDLE;
            else                   state <= LD_WL;
          end
        end

        CPU_RST: state <= RUN;

        RUN: begin
          if (halt) begin
            idx   <= '0;
            state <= REP_SEND;
          end
        end

        STEP: begin
          idx   <= '0;
          state <= REP_SEND;
        end

        REP_SEND: begin
          if (!i_tx_busy) begin
            o_tx_data  <= rep_byte;
            o_tx_start <= 1'b1;
            state      <= REP_WAIT;
          end
        end

        // One idle cycle so the transmitter can raise busy before the next byte.
        REP_WAIT: begin
          if (idx == 3'd5) begin
            state <= IDLE;
          end else begin
            idx   <= idx + 3'd1;
            state <= REP_SEND;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bip_run_ctrl.sv
module tb_bip_run_ctrl;

  localparam int NB_ADDR = 11;

  logic               clk;
  logic               rst;
  logic [7:0]         rx_data;
  logic               rx_valid;
  logic [7:0]         tx_data;
  logic               tx_start;
  logic               tx_busy;
  logic [NB_ADDR-1:0] ins_wr_addr;
  logic [15:0]        ins_wr_data;
  logic               ins_wr_en;
  logic               cpu_en;
  logic               cpu_rst;
  logic [NB_ADDR-1:0] cpu_pc;
  logic [15:0]        cpu_instruction;
  logic [15:0]        cpu_acc;
  logic [3:0]         state;

  int checks = 0;
  int fails  = 0;

  // Simple CPU model: PC advances on every enabled cycle, HALT sits at PC=5.
  logic rewind;
  assign cpu_acc         = 16'h00A5;
  assign cpu_instruction = (cpu_pc == 11'd5) ? 16'h0000 : 16'h0801;

  always @(posedge clk) begin
    if (rewind)        cpu_pc <= 11'd2;
    else if (!cpu_rst) cpu_pc <= '0;
    else if (cpu_en)   cpu_pc <= cpu_pc + 11'd1;
  end

  // Event monitors, sampled on the falling edge.
  logic [7:0]  tx_q[$];
  logic [10:0] wa_q[$];
  logic [15:0] wd_q[$];
  int en_cnt = 0;
  int rst_low_cnt = 0;

  always @(negedge clk) begin
    if (tx_start) tx_q.push_back(tx_data);
    if (ins_wr_en) begin
      wa_q.push_back(ins_wr_addr);
      wd_q.push_back(ins_wr_data);
    end
    if (cpu_en)   en_cnt++;
    if (!cpu_rst) rst_low_cnt++;
  end

  bip_run_ctrl dut (
    .i_clk             (clk),
    .i_rst             (rst),
    .i_rx_data         (rx_data),
    .i_rx_valid        (rx_valid),
    .o_tx_data         (tx_data),
    .o_tx_start        (tx_start),
    .i_tx_busy         (tx_busy),
    .o_ins_wr_addr     (ins_wr_addr),
    .o_ins_wr_data     (ins_wr_data),
    .o_ins_wr_en       (ins_wr_en),
    .o_cpu_en          (cpu_en),
    .o_cpu_rst         (cpu_rst),
    .i_cpu_pc          (cpu_pc),
    .i_cpu_instruction (cpu_instruction),
    .i_cpu_acc         (cpu_acc),
    .o_state           (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  // Waits (bounded) until the FSM is back in IDLE, then lets monitors settle.
  task automatic wait_idle(input string tag, input int budget);
    int n;
    n = 0;
    while (state !== 4'd0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, (n < budget)}, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  int base_tx, base_wr, base_en, base_rl;
  logic [7:0] exp_run  [6];
  logic [7:0] exp_step [6];

  initial begin
    exp_run  = '{8'h05, 8'h00, 8'hA5, 8'h00, 8'h05, 8'h00};
    exp_step = '{8'h02, 8'h00, 8'hA5, 8'h00, 8'h06, 8'h00};
    rst = 1'b0; rx_data = 8'h00; rx_valid = 1'b0; tx_busy = 1'b0; rewind = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state",    32'(state), 32'd0);
    check("rst_tx_start", 32'(tx_start), 32'd0);
    check("rst_tx_data",  32'(tx_data), 32'd0);
    check("rst_wr_en",    32'(ins_wr_en), 32'd0);
    check("rst_wr_addr",  32'(ins_wr_addr), 32'd0);
    check("rst_wr_data",  32'(ins_wr_data), 32'd0);
    check("rst_cpu_rst",  32'(cpu_rst), 32'd0);
    check("rst_cpu_en",   32'(cpu_en), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    check("cpu_rst_release", 32'(cpu_rst), 32'd1);

    // Unknown command byte is ignored
    send_byte(8'h41);
    check("ignore_byte_state", 32'(state), 32'd0);

    // Two-word load
    base_wr = wa_q.size();
    send_byte(8'h4C); check("ld_state_cnt_l", 32'(state), 32'd1);
    send_byte(8'h02); check("ld_state_cnt_h", 32'(state), 32'd2);
    send_byte(8'h00); check("ld_state_wl",    32'(state), 32'd3);
    send_byte(8'h34); check("ld_state_wh",    32'(state), 32'd4);
    send_byte(8'h12);
    send_byte(8'hCD);
    send_byte(8'hAB);
    repeat (2) @(negedge clk);
    check("ld_state_done", 32'(state), 32'd0);
    check("ld_wr_count", 32'(wa_q.size() - base_wr), 32'd2);
    if (wa_q.size() - base_wr == 2) begin
      check("ld_addr0", 32'(wa_q[base_wr]),     32'h0);
      check("ld_data0", 32'(wd_q[base_wr]),     32'h1234);
      check("ld_addr1", 32'(wa_q[base_wr + 1]), 32'h1);
      check("ld_data1", 32'(wd_q[base_wr + 1]), 32'hABCD);
    end

    // Zero-length load
    base_wr = wa_q.size();
    send_byte(8'h4C);
    send_byte(8'h00);
    send_byte(8'h00);
    check("zero_ld_state", 32'(state), 32'd0);
    repeat (2) @(negedge clk);
    check("zero_ld_no_wr", 32'(wa_q.size() - base_wr), 32'd0);

    // Run to halt
    base_tx = tx_q.size(); base_en = en_cnt; base_rl = rst_low_cnt;
    send_byte(8'h52);
    check("run_state_cpu_rst", 32'(state), 32'd5);
    check("run_cpu_rst_low",   32'(cpu_rst), 32'd0);
    @(negedge clk);
    check("run_state_run", 32'(state), 32'd6);
    wait_idle("run_done", 300);
    check("run_en_cycles",  32'(en_cnt - base_en), 32'd5);
    check("run_rst_cycles", 32'(rst_low_cnt - base_rl), 32'd1);
    check("run_tx_count",   32'(tx_q.size() - base_tx), 32'd6);
    if (tx_q.size() - base_tx == 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("run_tx_byte%0d", i), 32'(tx_q[base_tx + i]), 32'(exp_run[i]));

    // Single step with PC rewound to 2 and transmitter busy at report start
    @(negedge clk); rewind = 1'b1;
    @(negedge clk); rewind = 1'b0;
    tx_busy = 1'b1;
    base_tx = tx_q.size(); base_en = en_cnt; base_rl = rst_low_cnt;
    send_byte(8'h53);
    repeat (20) @(negedge clk);
    check("bp_state_send", 32'(state), 32'd8);
    check("bp_no_start",   32'(tx_q.size() - base_tx), 32'd0);
    tx_busy = 1'b0;
    wait_idle("step_done", 300);
    check("step_en_cycles", 32'(en_cnt - base_en), 32'd1);
    check("step_no_cpu_rst", 32'(rst_low_cnt - base_rl), 32'd0);
    check("step_tx_count",  32'(tx_q.size() - base_tx), 32'd6);
    if (tx_q.size() - base_tx == 6)
      for (int i = 0; i < 6; i++)
        check($sformatf("step_tx_byte%0d", i), 32'(tx_q[base_tx + i]), 32'(exp_step[i]));

    // Reset in the middle of a run
    send_byte(8'h52);
    @(negedge clk);
    check("mid_state_run", 32'(state), 32'd6);
    base_tx = tx_q.size();
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_state",   32'(state), 32'd0);
    check("mid_rst_cpu_en",  32'(cpu_en), 32'd0);
    check("mid_rst_cpu_rst", 32'(cpu_rst), 32'd0);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    check("mid_rst_no_tx",  32'(tx_q.size() - base_tx), 32'd0);
    check("mid_rst_idle",   32'(state), 32'd0);
    check("mid_rst_cpu_rst_back", 32'(cpu_rst), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
